// File: rtl/shifter_pkg.sv
// Shared helpers for the programmable row delay line: delay clamping and
// wrap-around pointer arithmetic, plus default sizing constants.
package shifter_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int MAX_DELAY_DEF = 37;

    // Delay 0 is meaningless for a delay line, so it behaves as a registered pass-through.
    function automatic int clamp_delay(input int d, input int max_d);
        if (d == 0)
            return 1;
        else if (d > max_d)
            return max_d;
        return d;
    endfunction

    // (p - k) mod max_d without ever going negative; valid for 0 <= k < max_d.
    function automatic int ptr_sub(input int p, input int k, input int max_d);
        int s;
        s = p + max_d - k;
        if (s >= max_d)
            s = s - max_d;
        return s;
    endfunction

endpackage

// File: rtl/shifter_row_buf_if.sv
// Stream/control bundle between the row-input source and the delay line.
interface shifter_row_buf_if
    import shifter_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CHANNELS = 1,
    parameter int DELAY_W  = 6
);
    logic [DELAY_W-1:0]         delay;
    logic [CHANNELS*DATA_W-1:0] in_data;
    logic                       in_valid;
    logic                       flush;
    logic [CHANNELS*DATA_W-1:0] out_data;
    logic                       out_valid;
    logic [DELAY_W-1:0]         fill_cnt;
    logic [DELAY_W-1:0]         delay_q;

    modport master (
        output delay, in_data, in_valid, flush,
        input  out_data, out_valid, fill_cnt, delay_q
    );

    modport slave (
        input  delay, in_data, in_valid, flush,
        output out_data, out_valid, fill_cnt, delay_q
    );
endinterface

// File: rtl/shifter_lane.sv
// One lane of sample storage: a MAX_DELAY-deep ring with a registered read
// port and a write-through bypass for the delay-of-one case.
module shifter_lane
    import shifter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int PTR_W     = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              bypass,
    input  logic [PTR_W-1:0]  wptr,
    input  logic [PTR_W-1:0]  rptr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] r_ring [MAX_DELAY];
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (we)
            r_ring[wptr] <= din;
    end

    // The read sees the pre-write ring, so the current sample only reaches the output through the bypass.
    always_ff @(posedge clk) begin
        if (!rst_n)
            r_dout <= '0;
        else if (we)
            r_dout <= bypass ? din : r_ring[rptr];
    end

    assign dout = r_dout;
endmodule

// File: rtl/shifter_row_buf.sv
// Runtime-programmable multi-lane delay line for the pooling row-input path;
// shared pointer, fill, delay and valid control drive CHANNELS ring lanes.
module shifter_row_buf
    import shifter_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CHANNELS  = 1,
    parameter int MAX_DELAY = MAX_DELAY_DEF,
    parameter int DELAY_W   = 6
) (
    input logic              clk,
    input logic              rst_n,
    shifter_row_buf_if.slave bus
);
    localparam int PTR_W = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    logic [PTR_W-1:0]           r_wptr;
    logic [DELAY_W-1:0]         r_fill;
    logic [DELAY_W-1:0]         r_delay_q;
    logic                       r_out_valid;
    logic [DELAY_W-1:0]         w_delay_clamped;
    logic [DELAY_W-1:0]         w_delay_eff;
    logic [DELAY_W-1:0]         w_fill_next;
    logic [PTR_W-1:0]           w_rptr;
    logic                       w_we;
    logic                       w_bypass;
    logic [CHANNELS*DATA_W-1:0] w_out_data;

    assign w_delay_clamped = DELAY_W'(clamp_delay(int'(bus.delay), MAX_DELAY));
    // An empty buffer adopts the requested delay on this same edge, so the first accept already uses it.
    assign w_delay_eff     = (r_fill == '0) ? w_delay_clamped : r_delay_q;
    assign w_fill_next     = (r_fill >= w_delay_eff) ? w_delay_eff : r_fill + 1'b1;
    assign w_rptr          = PTR_W'(ptr_sub(int'(r_wptr), int'(w_delay_eff) - 1, MAX_DELAY));
    assign w_bypass        = (w_delay_eff == DELAY_W'(1));
    assign w_we            = rst_n & bus.in_valid & ~bus.flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr      <= '0;
            r_fill      <= '0;
            r_out_valid <= 1'b0;
            r_delay_q   <= w_delay_clamped;
        end else begin
            if (r_fill == '0)
                r_delay_q <= w_delay_clamped;
            if (bus.flush) begin
                r_fill      <= '0;
                r_out_valid <= 1'b0;
            end else if (bus.in_valid) begin
                r_wptr      <= (r_wptr == PTR_W'(MAX_DELAY - 1)) ? '0 : r_wptr + 1'b1;
                r_fill      <= w_fill_next;
                r_out_valid <= (w_fill_next == w_delay_eff);
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        shifter_lane #(
            .DATA_W    (DATA_W),
            .MAX_DELAY (MAX_DELAY),
            .PTR_W     (PTR_W)
        ) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (w_we),
            .bypass (w_bypass),
            .wptr   (r_wptr),
            .rptr   (w_rptr),
            .din    (bus.in_data[c*DATA_W +: DATA_W]),
            .dout   (w_out_data[c*DATA_W +: DATA_W])
        );
    end

    assign bus.out_data  = w_out_data;
    assign bus.out_valid = r_out_valid;
    assign bus.fill_cnt  = r_fill;
    assign bus.delay_q   = r_delay_q;
endmodule
